// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Round-robin arbiter that shares one external multiplier between two
// requesters. A request is accepted in IDLE, its operands are held on the
// multiplier while mult_start is high (ISSUE), the product is returned on a
// valid/ready response channel (RESPOND), and the multiplier is then given a
// fixed number of quiet cycles (RECOVER) before the next request is taken.
// An operation whose multiplier never completes is abandoned after TIMEOUT
// ISSUE cycles and flagged with a one-cycle timeout_err pulse.
//
// Parameters
//   TIMEOUT      ISSUE cycles to wait for mult_done (2..255)
//   RECOVER_CYC  quiet cycles after every operation   (1..15)
//
// Ports
//   clk, reset_n              clock; asynchronous active-low reset
//   req0_valid/_a/_b/_ready   requester 0 operand handshake
//   req1_valid/_a/_b/_ready   requester 1 operand handshake
//   mult_a, mult_b            operands to the multiplier
//   mult_start                multiplier start level (high for all of ISSUE)
//   mult_done, mult_result    multiplier completion and 16-bit product
//   rsp_valid/_id/_result     response channel, rsp_ready from the consumer
//   timeout_err               one-cycle pulse when an operation is abandoned
// -----------------------------------------------------------------------------
module mult_arbiter #(
    parameter int TIMEOUT     = 15,
    parameter int RECOVER_CYC = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ready,
    output logic [7:0]  mult_a,
    output logic [7:0]  mult_b,
    output logic        mult_start,
    input  logic        mult_done,
    input  logic [15:0] mult_result,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    input  logic        rsp_ready,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2,
        RECOVER = 2'd3
    } state_t;

    // Terminal counter values: the counters run 0..N-1 so that exactly N
    // cycles are spent in the state.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] RECOVER_LAST = 4'(RECOVER_CYC - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // 1 = requester 1 was granted last
    logic [7:0]  mult_a_q, mult_a_d;
    logic [7:0]  mult_b_q, mult_b_d;
    logic        rsp_id_q, rsp_id_d;
    logic [15:0] rsp_result_q, rsp_result_d;
    logic [7:0]  issue_cnt_q, issue_cnt_d;
    logic [3:0]  recover_cnt_q, recover_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    logic        grant0;
    logic        grant1;

    // -------------------------------------------------------------------------
    // Round-robin grant. Only offered in IDLE; when both requesters are valid
    // the one not granted last wins. reset_n gates the grant so no ready is
    // shown while reset is held, even though the state already reads IDLE.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n && (state_q == IDLE)) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        mult_a_d      = mult_a_q;
        mult_b_d      = mult_b_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        issue_cnt_d   = issue_cnt_q;
        recover_cnt_d = recover_cnt_q;
        timeout_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d      = ISSUE;
                    last_grant_d = grant1;
                    rsp_id_d     = grant1;
                    mult_a_d     = grant1 ? req1_a : req0_a;
                    mult_b_d     = grant1 ? req1_b : req0_b;
                    issue_cnt_d  = 8'd0;
                end
            end

            ISSUE: begin
                // Completion is tested first so that a done arriving on the
                // very cycle the counter expires still produces a response.
                if (mult_done) begin
                    state_d      = RESPOND;
                    rsp_result_d = mult_result;
                end else if (issue_cnt_q == TIMEOUT_LAST) begin
                    state_d       = RECOVER;
                    recover_cnt_d = 4'd0;
                    timeout_err_d = 1'b1;   // visible in the first RECOVER cycle
                end else begin
                    issue_cnt_d = issue_cnt_q + 8'd1;
                end
            end

            RESPOND: begin
                if (rsp_ready) begin
                    state_d       = RECOVER;
                    recover_cnt_d = 4'd0;
                end
            end

            RECOVER: begin
                if (recover_cnt_q == RECOVER_LAST) begin
                    state_d = IDLE;
                end else begin
                    recover_cnt_d = recover_cnt_q + 4'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;      // requester 0 wins the first arbitration
            mult_a_q      <= 8'd0;
            mult_b_q      <= 8'd0;
            rsp_id_q      <= 1'b0;
            rsp_result_q  <= 16'd0;
            issue_cnt_q   <= 8'd0;
            recover_cnt_q <= 4'd0;
            timeout_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            mult_a_q      <= mult_a_d;
            mult_b_q      <= mult_b_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            issue_cnt_q   <= issue_cnt_d;
            recover_cnt_q <= recover_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign mult_start  = (state_q == ISSUE);
    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    assign rsp_valid   = (state_q == RESPOND);
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//
// Self-checking bench for mult_arbiter. A behavioural multiplier raises
// mult_done five cycles after mult_start rises (or never, in timeout mode).
// Each operation is checked cycle by cycle against the expected schedule:
// grant decision, ISSUE window, response hold, RECOVER window, and the
// 16-bit product computed from the requested operands.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

    localparam int TIMEOUT     = 15;
    localparam int RECOVER_CYC = 4;
    localparam int DONE_LAT    = 5;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic [7:0]  mult_a, mult_b;
    logic        mult_start;
    logic        mult_done;
    logic [15:0] mult_result;
    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_ready;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;
    int exp_last = 1;        // requester granted last, as the bench expects it
    bit no_done  = 1'b0;     // multiplier model never completes when set
    int start_cnt = 0;

    mult_arbiter #(
        .TIMEOUT     (TIMEOUT),
        .RECOVER_CYC (RECOVER_CYC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ready  (req1_ready),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_start  (mult_start),
        .mult_done   (mult_done),
        .mult_result (mult_result),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_ready   (rsp_ready),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: counts cycles since mult_start rose.
    always @(posedge clk) start_cnt <= mult_start ? start_cnt + 1 : 0;
    assign mult_done   = mult_start && (start_cnt == DONE_LAT) && !no_done;
    assign mult_result = {8'h00, mult_a} * {8'h00, mult_b};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Never two readys in the same cycle.
    always @(negedge clk) check("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);

    // One complete operation. Called at posedge+1 of a cycle in which the DUT
    // is expected to be IDLE; returns at posedge+1 of the next IDLE cycle.
    task automatic run_op(input string tag, input logic v0, input logic v1,
                          input logic [7:0] a0, input logic [7:0] b0,
                          input logic [7:0] a1, input logic [7:0] b1,
                          input int rsp_delay, input bit expect_timeout);
        int          win;
        int          issue_n;
        logic [7:0]  ea, eb;
        logic [15:0] prod;

        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp_ready  = 1'b0;
        no_done    = expect_timeout;

        if (v0 && v1) win = (exp_last == 1) ? 0 : 1;
        else          win = v0 ? 0 : 1;
        ea   = (win == 0) ? a0 : a1;
        eb   = (win == 0) ? b0 : b1;
        prod = {8'h00, ea} * {8'h00, eb};

        // Cycle 0: arbitration in IDLE
        @(negedge clk);
        check({tag, ":ready0"}, req0_ready, win == 0);
        check({tag, ":ready1"}, req1_ready, win == 1);
        check({tag, ":idle_start"}, mult_start, 0);
        exp_last = win;

        // ISSUE window
        issue_n = expect_timeout ? TIMEOUT : DONE_LAT + 1;
        for (int i = 1; i <= issue_n; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, ":issue_start"}, mult_start, 1);
            check({tag, ":issue_a"}, mult_a, ea);
            check({tag, ":issue_b"}, mult_b, eb);
            check({tag, ":issue_rdy"}, {req0_ready, req1_ready}, 0);
            check({tag, ":issue_rsp"}, rsp_valid, 0);
            check({tag, ":issue_to"}, timeout_err, 0);
        end

        // RESPOND window: rsp_ready low for rsp_delay cycles, then high
        if (!expect_timeout) begin
            for (int i = 0; i <= rsp_delay; i++) begin
                @(posedge clk); #1;
                rsp_ready = (i == rsp_delay);
                @(negedge clk);
                check({tag, ":rsp_valid"}, rsp_valid, 1);
                check({tag, ":rsp_id"}, rsp_id, win);
                check({tag, ":rsp_result"}, rsp_result, prod);
                check({tag, ":rsp_start"}, mult_start, 0);
                check({tag, ":rsp_rdy"}, {req0_ready, req1_ready}, 0);
            end
        end

        // RECOVER window
        for (int i = 0; i < RECOVER_CYC; i++) begin
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            check({tag, ":rec_start"}, mult_start, 0);
            check({tag, ":rec_rsp"}, rsp_valid, 0);
            check({tag, ":rec_rdy"}, {req0_ready, req1_ready}, 0);
            check({tag, ":rec_to"}, timeout_err, expect_timeout && (i == 0));
            check({tag, ":rec_a"}, mult_a, ea);
        end

        @(posedge clk); #1;
        no_done = 1'b0;
    endtask

    initial begin
        logic [1:0] v;
        reset_n    = 1'b0;
        req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00;
        rsp_ready  = 1'b0;

        // Reset values
        #2;
        check("rst_start",  mult_start, 0);
        check("rst_rsp",    rsp_valid, 0);
        check("rst_to",     timeout_err, 0);
        check("rst_rdy",    {req0_ready, req1_ready}, 0);
        check("rst_ab",     {mult_a, mult_b}, 0);
        check("rst_result", rsp_result, 0);
        check("rst_id",     rsp_id, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        // First request right after reset: 0xFF * 0xFF
        run_op("ff_ff", 1, 0, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 0);

        // Operand corner cases
        run_op("zero",  1, 0, 8'h00, 8'h80, 8'h00, 8'h00, 1, 0);
        run_op("x80x2", 0, 1, 8'h00, 8'h00, 8'h80, 8'h02, 0, 0);

        // Both valids held: grants alternate 0,1,0,1
        for (int k = 0; k < 4; k++)
            run_op("rr", 1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 0);

        // Response back-pressure for 10 cycles
        run_op("hold", 1, 1, 8'hA5, 8'h3C, 8'h5A, 8'hC3, 10, 0);

        // Multiplier never completes
        run_op("timeout", 0, 1, 8'h00, 8'h00, 8'h11, 8'h22, 0, 1);

        // Randomized traffic
        for (int k = 0; k < 24; k++) begin
            v = 2'($urandom_range(1, 3));
            run_op("rand", v[0], v[1], 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
        end

        // Reset during ISSUE: requester 0 is granted so last-grant becomes 0
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req1_valid = 1'b0;
        @(negedge clk);
        check("mid_ready0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check("mid_issue", mult_start, 1);
        @(posedge clk); #3;
        reset_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("mid_rst_start",  mult_start, 0);
        check("mid_rst_ab",     {mult_a, mult_b}, 0);
        check("mid_rst_rsp",    rsp_valid, 0);
        check("mid_rst_result", rsp_result, 0);
        check("mid_rst_id",     rsp_id, 0);
        check("mid_rst_rdy",    {req0_ready, req1_ready}, 0);
        @(negedge clk);
        check("mid_rst_to",     timeout_err, 0);
        check("mid_rst_hold",   {mult_start, rsp_valid, req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        reset_n  = 1'b1;
        exp_last = 1;
        run_op("post_rst", 1, 1, 8'h0F, 8'h0E, 8'h77, 8'h66, 0, 0);

        // Quiet bus: no ready, no start
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("quiet", {req0_ready, req1_ready, mult_start, rsp_valid}, 0);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum number of ISSUE cycles to wait for mult_done; legal range 2..255.
REQ-002 Parameter RECOVER_CYC, default 4: number of multiplier quiet cycles after each operation; legal range 1..15.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req0_valid / req1_valid  in  1  requester 0/1 has an operand pair pending.
REQ-006 req0_a, req0_b / req1_a, req1_b  in  8 each  requester operands.
REQ-007 req0_ready / req1_ready  out  1  request accepted this cycle; combinational from state, valids and the last-grant flag.
REQ-008 mult_a, mult_b  out  8 each  operands to the multiplier.
REQ-009 mult_start  out  1  multiplier start level.
REQ-010 mult_done  in  1  multiplier completion.
REQ-011 mult_result  in  16  multiplier product.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_id  out  1  requester index of the response.
REQ-014 rsp_result  out  16  registered product.
REQ-015 rsp_ready  in  1  consumer accepts the response.
REQ-016 timeout_err  out  1  one-cycle pulse when an operation is abandoned.

Function
REQ-017 The FSM shall have four states: IDLE, ISSUE, RESPOND and RECOVER.
REQ-018 IDLE: the block shall grant when any valid is high; a transfer occurs when valid and ready are both high; on that edge it captures operands and id and moves to ISSUE.
REQ-019 Arbitration shall be round-robin: with both valids high, the requester not granted last wins; with one valid high, that requester wins.
REQ-020 At most one readyX shall be high in any cycle, and only in IDLE.
REQ-021 ISSUE: mult_start shall be 1; mult_a and mult_b shall hold the captured operands stable for every ISSUE cycle.
REQ-022 ISSUE: when mult_done is sampled 1, the block shall register mult_result into rsp_result and move to RESPOND.
REQ-023 ISSUE: an 8-bit counter, cleared on entry, shall count ISSUE cycles; after TIMEOUT cycles without mult_done the block shall move to RECOVER and pulse timeout_err during the first RECOVER cycle, with no response produced.
REQ-024 mult_done sampled in the same cycle the counter expires shall count as completion, not timeout.
REQ-025 RESPOND: rsp_valid shall be 1, and rsp_id and rsp_result shall be held stable until rsp_ready; on the handshake edge the block moves to RECOVER.
REQ-026 RECOVER: mult_start shall be 0 for exactly RECOVER_CYC cycles, then the block returns to IDLE; mult_done shall be ignored outside ISSUE.
REQ-027 mult_start shall be 0 in IDLE, RESPOND and RECOVER.
REQ-028 mult_a and mult_b shall retain their last value outside ISSUE.
REQ-029 The last-grant flag shall update only on an accepted transfer.
REQ-030 rsp_result shall be the unmodified 16-bit mult_result, with no truncation.

Reset
REQ-031 While reset_n is low: state IDLE; mult_start, rsp_valid, timeout_err, req0_ready and req1_ready 0; mult_a, mult_b, rsp_result 0; rsp_id 0; counters 0; last-grant = 1, so requester 0 wins first.
REQ-032 Reset asserted mid-operation shall abandon the operation immediately, with no response and no timeout_err.
REQ-033 After reset_n rises, a request shall be acceptable on the first clock edge.

Verification
REQ-034 Bench multiplier model: raises mult_done 5 cycles after mult_start rises; produces mult_result = a*b.
REQ-035 req0 = 0xFF, 0xFF accepted in cycle 0 -> mult_start high cycles 1-6; rsp_valid high from cycle 7 with rsp_result 0xFE01 and rsp_id 0.
REQ-036 Both valids held high for 4 operations -> grant order 0, 1, 0, 1; each rsp_id matches its grant; never two readys in one cycle.
REQ-037 rsp_ready held low 10 cycles -> rsp_valid, rsp_id and rsp_result stable throughout; no new ready until RECOVER_CYC cycles after the handshake.
REQ-038 Model never raises mult_done -> timeout_err one pulse after 15 ISSUE cycles; no rsp_valid; IDLE after 4 RECOVER cycles.
REQ-039 reset_n pulsed low during ISSUE -> all outputs take their reset values asynchronously; the next request is served by requester 0 with correct results.
REQ-040 Operands 0x00 and 0x80 -> rsp_result 0x0000; operands 0x80 and 0x02 -> rsp_result 0x0100.
